a2d_sequencer: RTL and testbench
================================

# a2d_sequencer

Round-robin conversion scheduler for the SPI A2D interface. Sweeps the enabled channels in ascending order by pulsing `strt_cnv` with `chnnl` held stable, and waits for the rising edge of `cnv_cmplt`. Stores each 12-bit `res` in a per-channel result bank that downstream logic reads at any time. Sits between the A2D interface and its consumers, so the interface is shared by all channels without software sequencing.

## Interface
- `GAP_CYC`, 1024: idle cycles between the end of one sweep and the start of the next (min 1).
- `TIMEOUT`, 4096: cycles allowed in WAIT before a conversion is abandoned.
- `clk` in 1: system clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en` in 1: level; continuous sweeping while high.
- `ch_mask` in 8: channel enable bits; bit i enables channel i.
- `cnv_cmplt` in 1: completion level from the A2D interface.
- `res` in 12: conversion result from the A2D interface.
- `rd_sel` in 3: result bank read address.
- `strt_cnv` out 1: one-cycle start pulse to the A2D interface. Flop output.
- `chnnl` out 3: channel to convert. Flop output, stable from START through WAIT.
- `rd_data` out 12: combinational read of `bank[rd_sel]`.
- `valid` out 8: bit i is set once channel i holds a result.
- `sweep_done` out 1: one-cycle pulse when a sweep finishes.
- `err` out 1: sticky; set on any timeout. Cleared only by reset.

## Operation
- States: IDLE, SEL, START, WAIT, GAP.
- **IDLE**
  - If `en` and `ch_mask != 0`: latch `ch_mask` into `pend`, then go to SEL.
  - Otherwise stay in IDLE.
- **SEL**
  - If `pend != 0`: load `chnnl` with the index of the lowest set bit of `pend`, clear that bit, then go to START.
  - If `pend == 0`: pulse `sweep_done`, load the gap counter, then go to GAP.
- **START**
  - `strt_cnv = 1` for this cycle only.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - rise = `cnv_cmplt & ~cmplt_q`, where `cmplt_q` is `cnv_cmplt` registered every cycle.
  - On rise: write `res` to `bank[chnnl]`, set `valid[chnnl]`, then go to SEL.
  - If the timeout counter reaches `TIMEOUT-1` with no rise: set `err`, leave the bank and `valid` unchanged, then go to SEL.
  - A `cnv_cmplt` level that is already high on entry is ignored. Only a 0→1 transition counts.
- **GAP**
  - Count down `GAP_CYC` cycles, then go to IDLE.
  - A new sweep begins in IDLE only if `en` is still high.
- Mask changes during a sweep take effect at the next sweep only, because `pend` is latched in IDLE.
- `en` falling mid-sweep: the current conversion and sweep run to completion, then the block parks in IDLE after GAP.
- `ch_mask == 0` with `en = 1`: stays in IDLE. No `strt_cnv`, no `sweep_done`.
- The bank is 8×12 flops. Bank entries are overwritten only by a new successful conversion.

## Timing
- Reset values:
  - state = IDLE
  - `strt_cnv` = 0, `chnnl` = 0, `sweep_done` = 0, `err` = 0
  - `valid` = 0, bank = 0, `cmplt_q` = 0
  - `rd_data` = 0 (it reads the bank)
- Reset asserted in any state aborts immediately. After release the block restarts from IDLE, and all results are invalid.
- Start latency, with `en` and the mask sampled high at edge 0:
  - SEL during cycle 1.
  - `strt_cnv` high during cycle 2 only, with `chnnl` valid in the same cycle.
- Result capture: the bank and `valid` update at the edge where rise is detected. They are visible on `rd_data` the cycle after.
- Channel turnaround: 2 cycles from the capture edge to the next `strt_cnv` (SEL, then START).
- After the last channel:
  - `sweep_done` is high in the cycle after the capture edge (the SEL cycle).
  - The next possible `strt_cnv` comes `GAP_CYC`+3 cycles later.
- The timeout counter is wide enough for `TIMEOUT-1` and saturates; it cannot wrap.

## Test plan
- Single channel:
  - Stimulus: `ch_mask` = 0x04, `en` = 1, model returns `res` = 0xABC.
  - Required: one `strt_cnv` with `chnnl` = 2; `bank[2]` = 0xABC; `valid` = 0x04; `sweep_done` pulses once per sweep, with `GAP_CYC` gap between sweeps.
- Full sweep:
  - Stimulus: `ch_mask` = 0xFF, model returns `res` = 0x100+ch.
  - Required: `chnnl` order 0..7; every `bank[i]` = 0x100+i; `valid` = 0xFF; exactly 2 idle cycles between capture and the next `strt_cnv`.
- Stale completion:
  - Stimulus: `cnv_cmplt` held high through START, drops 5 cycles into WAIT, rises 40 cycles later.
  - Required: capture only at the later rise.
- Timeout:
  - Stimulus: `ch_mask` = 0x03, model never completes channel 0.
  - Required: `err` = 1 after `TIMEOUT` cycles; channel 1 still converts; `valid` = 0x02.
- Enable and mask changes:
  - Stimulus: `en` dropped and `ch_mask` changed to 0x00 during channel 3 of a 0xFF sweep.
  - Required: channels 3..7 complete; one `sweep_done`; then parked in IDLE with no further `strt_cnv`.
- Reset mid-WAIT:
  - Stimulus: assert `rst_n` = 0 mid-WAIT.
  - Required: all outputs return to reset values immediately; after release with `en` = 1 the sweep restarts at the lowest enabled channel.

Source files
------------

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin scheduler that sweeps enabled A2D channels in
// ascending order and keeps the latest 12-bit result of each channel in a bank.
`default_nettype none

module a2d_sequencer #(
  parameter int GAP_CYC = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  ch_mask,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_sel,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] rd_data,
  output logic [7:0]  valid,
  output logic        sweep_done,
  output logic        err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LOAD = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      pend;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gcnt;
  logic            cmplt_q;
  logic [11:0]     bank [8];
  logic [2:0]      low_idx;
  logic            rise;
  logic            t_expired;
  logic            go;

  assign rise       = cnv_cmplt & ~cmplt_q;
  assign t_expired  = (tcnt == T_LAST);
  assign go         = en && (ch_mask != 8'd0);
  assign sweep_done = (state == SEL) && (pend == 8'd0);
  assign rd_data    = bank[rd_sel];

  // Lowest pending channel wins, so channels are served in ascending order.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) low_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = SEL;
      SEL:     state_nxt = (pend != 8'd0) ? START : GAP;
      START:   state_nxt = WAIT;
      WAIT:    if (rise || t_expired) state_nxt = SEL;
      GAP:     if (gcnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strt_cnv <= 1'b0;
      chnnl    <= 3'd0;
      err      <= 1'b0;
      valid    <= 8'd0;
      pend     <= 8'd0;
      tcnt     <= '0;
      gcnt     <= '0;
      cmplt_q  <= 1'b0;
      for (int i = 0; i < 8; i++) bank[i] <= 12'd0;
    end else begin
      cmplt_q  <= cnv_cmplt;
      strt_cnv <= (state == SEL) && (pend != 8'd0);
      case (state)
        IDLE: if (go) pend <= ch_mask;
        SEL: begin
          if (pend != 8'd0) begin
            chnnl         <= low_idx;
            pend[low_idx] <= 1'b0;
          end else begin
            gcnt <= G_LOAD;
          end
        end
        START: tcnt <= '0;
        WAIT: begin
          // A completion on the same cycle as the last timeout count still counts.
          if (rise) begin
            bank[chnnl]  <= res;
            valid[chnnl] <= 1'b1;
          end else if (t_expired) begin
            err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        GAP: if (gcnt != '0) gcnt <= gcnt - GW'(1);
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_a2d_sequencer.sv
// tb_a2d_sequencer: randomized scoreboard bench with an A2D responder model
// and a reference result bank.
`default_nettype none

module tb_a2d_sequencer;

  localparam int GAP_CYC  = 16;
  localparam int TIMEOUT  = 64;
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STALE  = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  ch_mask;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [2:0]  rd_sel;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] rd_data;
  logic [7:0]  valid;
  logic        sweep_done;
  logic        err;

  a2d_sequencer #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
    .cnv_cmplt(cnv_cmplt), .res(res), .rd_sel(rd_sel),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .rd_data(rd_data),
    .valid(valid), .sweep_done(sweep_done), .err(err)
  );

  typedef struct {
    int kind;  // 0 = start pulse, 1 = sweep_done
    int ch;
    int chk;   // 0 none, 1 relative to last completion, 2 relative to last sweep_done
  } ev_t;

  ev_t         exp_q[$];
  logic [11:0] ref_bank [8];
  logic [7:0]  ref_valid;
  logic        ref_err;
  int          resp_mode [8];
  int          resp_dly  [8];
  logic [11:0] resp_val  [8];
  int          stale_req;
  int          cyc;
  int          rise_cyc;
  int          last_done_cyc;
  int          strt_seen;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input int ch);
    ev_t e;
    int  want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d ch=%0d, required none (cycle %0d)", kind, ch, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.ch != ch) begin
      errors++;
      $display("FAIL event_order: got kind=%0d ch=%0d, required kind=%0d ch=%0d", kind, ch, e.kind, e.ch);
    end
    if (e.chk != 0) begin
      want = (e.chk == 1) ? rise_cyc + ((kind == 1) ? 1 : 2) : last_done_cyc + GAP_CYC + 3;
      chk($sformatf("event_timing_k%0d_ch%0d", kind, ch), cyc, want);
    end
  endtask

  // Monitor: every start pulse and sweep_done is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (strt_cnv) begin
          strt_seen++;
          check_ev(0, int'(chnnl));
        end
        if (sweep_done) begin
          check_ev(1, 0);
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_to(input int tgt);
    while (cyc < tgt && rst_n) begin
      @(posedge clk); #1;
    end
  endtask

  // A2D interface model: answers each start pulse according to resp_mode.
  initial begin
    int ch, s, tgt, stale_ack;
    stale_ack = 0;
    cnv_cmplt = 1'b0;
    res       = 12'd0;
    forever begin
      @(negedge clk);
      if (stale_req != stale_ack) begin
        cnv_cmplt = 1'b1;
        stale_ack = stale_req;
      end
      if (rst_n && strt_cnv) begin
        ch = int'(chnnl);
        s  = cyc;
        if (resp_mode[ch] == M_NEVER) begin
          while (cyc < s + TIMEOUT) @(negedge clk);
          chk("err_before_timeout", int'(err), int'(ref_err));
          @(negedge clk);
          chk("err_after_timeout", int'(err), 1);
          ref_err  = 1'b1;
          rise_cyc = s + TIMEOUT;
        end else begin
          if (resp_mode[ch] == M_STALE) begin
            wait_to(s + 6);
            cnv_cmplt = 1'b0;
            wait_to(s + 46);
            chk("stale_no_capture", int'(valid[ch]), int'(ref_valid[ch]));
          end else begin
            tgt = s + ((resp_dly[ch] != 0) ? resp_dly[ch] : int'($urandom_range(1, 8)));
            wait_to(tgt);
          end
          if (!rst_n) begin
            cnv_cmplt = 1'b0;
            continue;
          end
          res           = resp_val[ch];
          cnv_cmplt     = 1'b1;
          rise_cyc      = cyc;
          ref_bank[ch]  = resp_val[ch];
          ref_valid[ch] = 1'b1;
          @(posedge clk); #1;
          cnv_cmplt = 1'b0;
          res       = 12'($urandom);
        end
      end
    end
  end

  task automatic push_sweep(input logic [7:0] m, input int first_chk);
    ev_t e;
    bit  first;
    first = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.kind = 0; e.ch = i; e.chk = first ? first_chk : 1;
        exp_q.push_back(e);
        first = 1'b0;
      end
    end
    e.kind = 1; e.ch = 0; e.chk = 1;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals();
    chk("rst_strt_cnv", int'(strt_cnv), 0);
    chk("rst_chnnl", int'(chnnl), 0);
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 8; i++) ref_bank[i] = 12'd0;
    ref_valid = 8'd0;
    ref_err   = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b0;
    rd_sel = 3'($urandom_range(0, 7));
    clear_model();
    @(negedge clk);
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("events_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle_check();
    int n0;
    n0 = strt_seen;
    repeat (GAP_CYC + 8) @(negedge clk);
    chk("parked_no_strt", strt_seen, n0);
  endtask

  task automatic check_bank();
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      @(negedge clk);
      chk($sformatf("bank%0d", i), int'(rd_data), int'(ref_bank[i]));
    end
    chk("valid", int'(valid), int'(ref_valid));
    chk("err", int'(err), int'(ref_err));
  endtask

  task automatic wait_strt_ch(input int ch, input int budget);
    int n;
    n = 0;
    while (!(strt_cnv && int'(chnnl) == ch) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_ch%0d", ch), int'(strt_cnv && int'(chnnl) == ch), 1);
  endtask

  task automatic run_sweep(input logic [7:0] m, input int budget);
    ch_mask = m;
    push_sweep(m, 0);
    en = 1'b1;
    wait_empty(budget);
    en = 1'b0;
    idle_check();
    check_bank();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ch_mask = 8'd0; rd_sel = 3'd0;
    checks = 0; errors = 0; cyc = 0; rise_cyc = 0; last_done_cyc = 0;
    strt_seen = 0; stale_req = 0;
    for (int i = 0; i < 8; i++) begin
      resp_mode[i] = M_NORMAL; resp_dly[i] = 0; resp_val[i] = 12'(32'h100 + i);
    end
    clear_model();

    // Single channel, two back-to-back sweeps separated by the gap.
    do_reset();
    resp_val[2] = 12'hABC;
    ch_mask = 8'h04;
    push_sweep(8'h04, 0);
    push_sweep(8'h04, 2);
    en = 1'b1;
    wait_empty(400);
    en = 1'b0;
    idle_check();
    check_bank();

    // Full sweep.
    do_reset();
    for (int i = 0; i < 8; i++) resp_val[i] = 12'(32'h100 + i);
    run_sweep(8'hFF, 400);

    // Stale completion level on entry to WAIT.
    do_reset();
    resp_mode[5] = M_STALE;
    resp_val[5]  = 12'h5A5;
    stale_req++;
    repeat (2) @(negedge clk);
    run_sweep(8'h20, 400);
    resp_mode[5] = M_NORMAL;

    // Timeout on channel 0, channel 1 still converts.
    do_reset();
    resp_mode[0] = M_NEVER;
    resp_val[1]  = 12'h321;
    run_sweep(8'h03, TIMEOUT + 400);
    resp_mode[0] = M_NORMAL;

    // Enable and mask dropped during channel 3.
    do_reset();
    for (int i = 0; i < 8; i++) resp_val[i] = 12'($urandom);
    ch_mask = 8'hFF;
    push_sweep(8'hFF, 0);
    en = 1'b1;
    wait_strt_ch(3, 400);
    en = 1'b0;
    ch_mask = 8'h00;
    wait_empty(400);
    idle_check();
    check_bank();

    // Enabled with an empty mask: nothing happens.
    ch_mask = 8'h00;
    en = 1'b1;
    idle_check();
    en = 1'b0;

    // Random masks and results accumulating into the bank.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) resp_val[i] = 12'($urandom);
      run_sweep(8'($urandom_range(1, 255)), 400);
    end

    // Reset in the middle of WAIT.
    do_reset();
    resp_val[1] = 12'($urandom);
    resp_val[3] = 12'($urandom);
    resp_dly[1] = 30;
    ch_mask = 8'h0A;
    push_sweep(8'h0A, 0);
    en = 1'b1;
    wait_strt_ch(1, 100);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    rd_sel = 3'd1;
    clear_model();
    @(negedge clk);
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    resp_dly[1] = 0;
    push_sweep(8'h0A, 0);
    rst_n = 1'b1;
    wait_empty(400);
    en = 1'b0;
    idle_check();
    check_bank();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
